column_raster_engine: RTL

Parametrised successor to the fixed 160x120 frame drawer. Once per frame it optionally clears the frame buffer, then walks every screen column, requests that column's wall slice (size, skip flag, colour) from an external ray caster over a req/ack handshake, centres the slice vertically and streams the resulting pixels to the VGA frame-buffer writer. It adds per-column ceiling/floor fill mode and output back-pressure; it sits between the ray-cast unit and vga_adapter.

---
 rtl/column_raster_engine.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/column_raster_engine.sv
// Column raster engine: per frame, optionally clears the frame buffer, then walks every screen
// column, fetches that column's wall slice from the ray caster over req/ack, centres it
// vertically and streams the resulting pixels to the frame-buffer writer with back-pressure.
module column_raster_engine #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned COLOR_W   = 3,
    parameter int unsigned FILL_MODE = 0,
    parameter int unsigned X_W       = $clog2(SCREEN_W),
    parameter int unsigned Y_W       = $clog2(SCREEN_H)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic [COLOR_W-1:0] ceil_color,
    input  logic [COLOR_W-1:0] floor_color,
    output logic               slice_req,
    output logic [X_W-1:0]     slice_col,
    input  logic               slice_ack,
    input  logic [Y_W:0]       slice_size,
    input  logic               slice_skip,
    input  logic [COLOR_W-1:0] slice_color,
    output logic               plot,
    input  logic               plot_ready,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [X_W-1:0] XLast    = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] YLast    = Y_W'(SCREEN_H - 1);
    localparam logic [Y_W:0]   HSize    = (Y_W + 1)'(SCREEN_H);
    localparam bit             FillMode = (FILL_MODE != 0);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StReq,
        StLoc,
        StDraw,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [X_W-1:0]     col_q, col_d;
    logic [COLOR_W-1:0] ceil_q, ceil_d;
    logic [COLOR_W-1:0] floor_q, floor_d;
    logic [COLOR_W-1:0] wall_q, wall_d;
    // Effective wall height: already saturated and forced to zero for skipped columns.
    logic [Y_W:0]       size_q, size_d;
    logic [Y_W:0]       top_q, top_d;
    logic [Y_W:0]       bot_q, bot_d;
    logic               plot_q, plot_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;

    logic [Y_W:0]       loc_top;
    logic [Y_W:0]       loc_bot;
    logic               beat;
    logic               last_draw_px;

    // Colour of row yy in ceiling/wall/floor fill mode, given the slice span [t, b).
    function automatic logic [COLOR_W-1:0] fill_color(
        input logic [Y_W-1:0]     yy,
        input logic [Y_W:0]       t,
        input logic [Y_W:0]       b,
        input logic [COLOR_W-1:0] c_ceil,
        input logic [COLOR_W-1:0] c_wall,
        input logic [COLOR_W-1:0] c_floor
    );
        logic [Y_W:0] ext;
        ext = {1'b0, yy};
        if (ext < t) begin
            return c_ceil;
        end else if (ext < b) begin
            return c_wall;
        end else begin
            return c_floor;
        end
    endfunction

    // Vertical centring of the current slice; odd leftovers put the wall half a pixel high.
    always_comb begin
        loc_top = (HSize - size_q) >> 1;
        loc_bot = loc_top + size_q;
    end

    // Beat handshake and end-of-column detection for the draw pass.
    always_comb begin
        beat = plot_q & plot_ready;
        if (FillMode) begin
            last_draw_px = (y_q == YLast);
        end else begin
            last_draw_px = (({1'b0, y_q} + 1'b1) == bot_q);
        end
    end

    // Next-state logic: frame sequencing, slice capture and pixel stepping.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ceil_d  = ceil_q;
        floor_d = floor_q;
        wall_d  = wall_q;
        size_d  = size_q;
        top_d   = top_q;
        bot_d   = bot_q;
        plot_d  = plot_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    ceil_d  = ceil_color;
                    floor_d = floor_color;
                    col_d   = '0;
                    if (FillMode) begin
                        state_d = StReq;
                    end else begin
                        // First clear pixel is presented straight away; color_q then holds
                        // the clear colour for the rest of the pass.
                        state_d = StClear;
                        plot_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        color_d = clear_color;
                    end
                end
            end

            StClear: begin
                if (beat) begin
                    if (x_q == XLast) begin
                        x_d = '0;
                        if (y_q == YLast) begin
                            plot_d  = 1'b0;
                            state_d = StReq;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end

            StReq: begin
                if (slice_ack) begin
                    wall_d = slice_color;
                    if (slice_skip) begin
                        size_d = '0;
                    end else if (slice_size > HSize) begin
                        size_d = HSize;
                    end else begin
                        size_d = slice_size;
                    end
                    state_d = StLoc;
                end
            end

            StLoc: begin
                top_d = loc_top;
                bot_d = loc_bot;
                x_d   = col_q;
                if (FillMode) begin
                    plot_d  = 1'b1;
                    y_d     = '0;
                    color_d = fill_color('0, loc_top, loc_bot, ceil_q, wall_q, floor_q);
                    state_d = StDraw;
                end else if (size_q == '0) begin
                    // Empty column: no pixels, move straight on.
                    if (col_q == XLast) begin
                        state_d = StDone;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = StReq;
                    end
                end else begin
                    plot_d  = 1'b1;
                    y_d     = loc_top[Y_W-1:0];
                    color_d = wall_q;
                    state_d = StDraw;
                end
            end

            StDraw: begin
                if (beat) begin
                    if (last_draw_px) begin
                        plot_d = 1'b0;
                        if (col_q == XLast) begin
                            state_d = StDone;
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = StReq;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                        if (FillMode) begin
                            color_d = fill_color(y_q + 1'b1, top_q, bot_q, ceil_q, wall_q,
                                                 floor_q);
                        end else begin
                            color_d = wall_q;
                        end
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                plot_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            ceil_q  <= '0;
            floor_q <= '0;
            wall_q  <= '0;
            size_q  <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ceil_q  <= ceil_d;
            floor_q <= floor_d;
            wall_q  <= wall_d;
            size_q  <= size_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

    assign slice_req  = (state_q == StReq);
    assign slice_col  = col_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign color      = color_q;

endmodule
